// File: rtl/mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared definitions for the two-master memory arbiter: FSM state encoding,
// default transfer timeout, grant-ID constants used by the last-grant flag,
// and the width of the timeout counter.
// ---------------------------------------------------------------------------
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      GNT_C = 2'b01,
      GNT_D = 2'b10
   } arb_state_e;

   localparam int DEFAULT_TIMEOUT = 255;

   // Encoding of the last-grant flag
   localparam logic GID_CPU = 1'b0;
   localparam logic GID_DMA = 1'b1;

   localparam int TIMER_W = 8;

endpackage

// File: rtl/arb_timer.sv
// ---------------------------------------------------------------------------
// arb_timer
// Counts cycles a granted transfer has been waiting for the memory ack and
// flags the cycle in which the wait reaches TIMEOUT.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : clear the count (grant change, ack, idle)
//   inc        : this cycle is a waiting cycle (mem_cyc=1, mem_ack=0)
//   expired    : this waiting cycle is the TIMEOUT-th one; the counter
//                restarts from zero on the following cycle
// ---------------------------------------------------------------------------
module arb_timer
   import mem_arbiter_pkg::*;
#(
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic inc,
   output logic expired
);

   // The count holds the number of waiting cycles already elapsed, so the
   // current waiting cycle is the TIMEOUT-th one when the count is TIMEOUT-1.
   localparam logic [TIMER_W-1:0] LIMIT = TIMER_W'(TIMEOUT - 1);

   logic [TIMER_W-1:0] cnt_q;
   logic [TIMER_W-1:0] cnt_d;

   assign expired = inc && (cnt_q == LIMIT);

   always_comb begin
      cnt_d = cnt_q;
      if (clr || expired) begin
         cnt_d = '0;
      end else if (inc) begin
         cnt_d = cnt_q + TIMER_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Two-master (CPU, disk DMA) to one memory slave arbiter. Grants are
// registered (one cycle request-to-grant latency), held while the granted
// master keeps cyc high, and alternated on ties. The request path to memory
// and the ack path back are combinational muxes of the granted master.
// A granted transfer that waits TIMEOUT cycles for mem_ack gets a one-cycle
// err pulse instead of an ack; the grant is kept.
//
// Ports:
//   clk, rst_n                               : clock, async active-low reset
//   c_cyc/c_we/c_strb/c_addr/c_data_i        : CPU request
//   c_ack/c_err/c_data_o                     : CPU response
//   d_cyc/d_we/d_strb/d_addr/d_data_i        : DMA request
//   d_ack/d_err/d_data_o                     : DMA response
//   mem_cyc/mem_we/mem_strb/mem_addr/mem_data_o : memory request
//   mem_ack/mem_data_i                       : memory response
// ---------------------------------------------------------------------------
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic        clk,
   input  logic        rst_n,
   // CPU master
   input  logic        c_cyc,
   input  logic        c_we,
   input  logic [3:0]  c_strb,
   input  logic [31:0] c_addr,
   input  logic [31:0] c_data_i,
   output logic        c_ack,
   output logic        c_err,
   output logic [31:0] c_data_o,
   // disk DMA master
   input  logic        d_cyc,
   input  logic        d_we,
   input  logic [3:0]  d_strb,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_data_i,
   output logic        d_ack,
   output logic        d_err,
   output logic [31:0] d_data_o,
   // memory slave
   output logic        mem_cyc,
   output logic        mem_we,
   output logic [3:0]  mem_strb,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_data_o,
   input  logic        mem_ack,
   input  logic [31:0] mem_data_i
);

   arb_state_e state_q;
   logic       last_q;

   logic gnt_c;
   logic gnt_d;
   logic leave;
   logic tmr_clr;
   logic tmr_inc;
   logic tmr_expired;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         last_q  <= GID_DMA;
      end else begin
         case (state_q)
            IDLE: begin
               if (c_cyc && d_cyc) begin
                  // Tie: the master not granted last time wins
                  if (last_q == GID_DMA) begin
                     state_q <= GNT_C;
                     last_q  <= GID_CPU;
                  end else begin
                     state_q <= GNT_D;
                     last_q  <= GID_DMA;
                  end
               end else if (c_cyc) begin
                  state_q <= GNT_C;
                  last_q  <= GID_CPU;
               end else if (d_cyc) begin
                  state_q <= GNT_D;
                  last_q  <= GID_DMA;
               end
            end
            GNT_C: begin
               if (!c_cyc) begin
                  if (d_cyc) begin
                     state_q <= GNT_D;
                     last_q  <= GID_DMA;
                  end else begin
                     state_q <= IDLE;
                  end
               end
            end
            GNT_D: begin
               if (!d_cyc) begin
                  if (c_cyc) begin
                     state_q <= GNT_C;
                     last_q  <= GID_CPU;
                  end else begin
                     state_q <= IDLE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign gnt_c = (state_q == GNT_C);
   assign gnt_d = (state_q == GNT_D);

   // Request mux; everything reads zero while idle
   always_comb begin
      mem_cyc    = 1'b0;
      mem_we     = 1'b0;
      mem_strb   = 4'h0;
      mem_addr   = 32'h0;
      mem_data_o = 32'h0;
      if (gnt_c) begin
         mem_cyc    = c_cyc;
         mem_we     = c_we;
         mem_strb   = c_strb;
         mem_addr   = c_addr;
         mem_data_o = c_data_i;
      end else if (gnt_d) begin
         mem_cyc    = d_cyc;
         mem_we     = d_we;
         mem_strb   = d_strb;
         mem_addr   = d_addr;
         mem_data_o = d_data_i;
      end
   end

   // The granted master dropping cyc means the grant changes at this edge
   assign leave   = (gnt_c && !c_cyc) || (gnt_d && !d_cyc);
   assign tmr_clr = (state_q == IDLE) || mem_ack || leave;
   assign tmr_inc = mem_cyc && !mem_ack;

   arb_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (tmr_clr),
      .inc     (tmr_inc),
      .expired (tmr_expired)
   );

   // tmr_expired already implies mem_ack=0, so an ack always wins over err
   assign c_ack = gnt_c && mem_ack;
   assign d_ack = gnt_d && mem_ack;
   assign c_err = gnt_c && tmr_expired;
   assign d_err = gnt_d && tmr_expired;

   assign c_data_o = mem_data_i;
   assign d_data_o = mem_data_i;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

   localparam int TO = 4;
   localparam logic [31:0] CA = 32'h0000_0200;
   localparam logic [31:0] DA = 32'h0000_0100;
   localparam logic [31:0] CD = 32'hC0DE_0001;
   localparam logic [31:0] DD = 32'hD0DE_0002;

   logic        clk;
   logic        rst_n;
   logic        c_cyc, c_we, c_ack, c_err;
   logic [3:0]  c_strb;
   logic [31:0] c_addr, c_data_i, c_data_o;
   logic        d_cyc, d_we, d_ack, d_err;
   logic [3:0]  d_strb;
   logic [31:0] d_addr, d_data_i, d_data_o;
   logic        mem_cyc, mem_we, mem_ack;
   logic [3:0]  mem_strb;
   logic [31:0] mem_addr, mem_data_o, mem_data_i;

   int checks;
   int errors;

   mem_arbiter #(.TIMEOUT(TO)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .c_cyc      (c_cyc),
      .c_we       (c_we),
      .c_strb     (c_strb),
      .c_addr     (c_addr),
      .c_data_i   (c_data_i),
      .c_ack      (c_ack),
      .c_err      (c_err),
      .c_data_o   (c_data_o),
      .d_cyc      (d_cyc),
      .d_we       (d_we),
      .d_strb     (d_strb),
      .d_addr     (d_addr),
      .d_data_i   (d_data_i),
      .d_ack      (d_ack),
      .d_err      (d_err),
      .d_data_o   (d_data_o),
      .mem_cyc    (mem_cyc),
      .mem_we     (mem_we),
      .mem_strb   (mem_strb),
      .mem_addr   (mem_addr),
      .mem_data_o (mem_data_o),
      .mem_ack    (mem_ack),
      .mem_data_i (mem_data_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // own: 0 = nobody, 1 = CPU, 2 = DMA (who the bench expects owns the bus)
   typedef struct {
      logic c;
      logic d;
      logic ack;
      int   own;
      logic cyc;
      logic cack;
      logic dack;
   } vec_t;

   vec_t tbl [18];

   // reference model state
   int m_own;
   int m_last;
   int m_wait;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic c, input logic d, input logic a);
      c_cyc   = c;
      d_cyc   = d;
      mem_ack = a;
   endtask

   function automatic logic [31:0] own_addr(input int own);
      return (own == 1) ? CA : (own == 2) ? DA : 32'h0;
   endfunction

   function automatic logic [31:0] own_data(input int own);
      return (own == 1) ? CD : (own == 2) ? DD : 32'h0;
   endfunction

   // Reference model: ownership rules and waiting-cycle count, advanced once
   // per clock edge using the inputs present at that edge.
   task automatic model_edge();
      logic req_c, req_d, wait_cyc;
      req_c    = c_cyc;
      req_d    = d_cyc;
      wait_cyc = (m_own == 1 && req_c || m_own == 2 && req_d) && !mem_ack;
      if (m_own != 0 && mem_ack) m_wait = 0;
      else if (wait_cyc) m_wait = (m_wait + 1 == TO) ? 0 : m_wait + 1;
      if (m_own == 0) begin
         if (req_c && req_d) m_own = (m_last == 2) ? 1 : 2;
         else if (req_c) m_own = 1;
         else if (req_d) m_own = 2;
         m_wait = 0;
      end else if (m_own == 1 && !req_c) begin
         m_own  = req_d ? 2 : 0;
         m_wait = 0;
      end else if (m_own == 2 && !req_d) begin
         m_own  = req_c ? 1 : 0;
         m_wait = 0;
      end
      if (m_own != 0) m_last = m_own;
   endtask

   task automatic model_check();
      logic        e_cyc, e_we, waiting, e_err;
      logic [3:0]  e_strb;
      logic [31:0] e_addr, e_data;
      e_cyc = 1'b0; e_we = 1'b0; e_strb = 4'h0; e_addr = 32'h0; e_data = 32'h0;
      if (m_own == 1) begin
         e_cyc = c_cyc; e_we = c_we; e_strb = c_strb; e_addr = c_addr; e_data = c_data_i;
      end else if (m_own == 2) begin
         e_cyc = d_cyc; e_we = d_we; e_strb = d_strb; e_addr = d_addr; e_data = d_data_i;
      end
      waiting = e_cyc && !mem_ack;
      e_err   = waiting && (m_wait + 1 == TO);
      chk("rnd_mem_cyc", {31'b0, mem_cyc}, {31'b0, e_cyc});
      chk("rnd_mem_we", {31'b0, mem_we}, {31'b0, e_we});
      chk("rnd_mem_strb", {28'b0, mem_strb}, {28'b0, e_strb});
      chk("rnd_mem_addr", mem_addr, e_addr);
      chk("rnd_mem_data", mem_data_o, e_data);
      chk("rnd_acks", {30'b0, c_ack, d_ack},
          {30'b0, (m_own == 1) && mem_ack, (m_own == 2) && mem_ack});
      chk("rnd_errs", {30'b0, c_err, d_err},
          {30'b0, (m_own == 1) && e_err, (m_own == 2) && e_err});
      chk("rnd_rdata", {c_data_o ^ mem_data_i} | {d_data_o ^ mem_data_i}, 32'h0);
   endtask

   initial begin
      checks = 0;
      errors = 0;

      // table: rows 0-4 DMA-only transfer, 5-8 simultaneous start from a
      // DMA-last state, 9-16 alternation, 17 mem_ack while idle
      tbl[0]  = '{1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{1'b0, 1'b1, 1'b0, 2, 1'b1, 1'b0, 1'b0};
      tbl[2]  = '{1'b0, 1'b1, 1'b1, 2, 1'b1, 1'b0, 1'b1};
      tbl[3]  = '{1'b0, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0};
      tbl[4]  = '{1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0};
      tbl[5]  = '{1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0};
      tbl[6]  = '{1'b1, 1'b1, 1'b1, 1, 1'b1, 1'b1, 1'b0};
      tbl[7]  = '{1'b0, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0};
      tbl[8]  = '{1'b0, 1'b1, 1'b1, 2, 1'b1, 1'b0, 1'b1};
      tbl[9]  = '{1'b1, 1'b1, 1'b0, 2, 1'b1, 1'b0, 1'b0};
      tbl[10] = '{1'b1, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0};
      tbl[11] = '{1'b1, 1'b1, 1'b1, 1, 1'b1, 1'b1, 1'b0};
      tbl[12] = '{1'b0, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0};
      tbl[13] = '{1'b1, 1'b1, 1'b1, 2, 1'b1, 1'b0, 1'b1};
      tbl[14] = '{1'b1, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0};
      tbl[15] = '{1'b1, 1'b1, 1'b1, 1, 1'b1, 1'b1, 1'b0};
      tbl[16] = '{1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0};
      tbl[17] = '{1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0};

      c_we = 1'b0; c_strb = 4'hF; c_addr = CA; c_data_i = CD;
      d_we = 1'b1; d_strb = 4'h3; d_addr = DA; d_data_i = DD;
      mem_data_i = 32'h5A5A_0000;

      // reset with every request input active
      rst_n = 1'b0;
      drive(1'b1, 1'b1, 1'b1);
      tick();
      tick();
      chk("rst_outputs", {24'b0, mem_cyc, mem_we, mem_strb, c_ack, d_ack},
          32'h0);
      chk("rst_errs", {30'b0, c_err, d_err}, 32'h0);
      rst_n = 1'b1;

      for (int i = 0; i < 18; i++) begin
         drive(tbl[i].c, tbl[i].d, tbl[i].ack);
         #2;
         chk($sformatf("tbl%0d_mem_cyc", i), {31'b0, mem_cyc}, {31'b0, tbl[i].cyc});
         chk($sformatf("tbl%0d_mem_addr", i), mem_addr, own_addr(tbl[i].own));
         chk($sformatf("tbl%0d_mem_data", i), mem_data_o, own_data(tbl[i].own));
         chk($sformatf("tbl%0d_mem_we", i), {31'b0, mem_we}, {31'b0, tbl[i].own == 2});
         chk($sformatf("tbl%0d_acks", i), {30'b0, c_ack, d_ack},
             {30'b0, tbl[i].cack, tbl[i].dack});
         chk($sformatf("tbl%0d_errs", i), {30'b0, c_err, d_err}, 32'h0);
         tick();
      end

      // timeout: CPU waits forever while DMA also requests
      drive(1'b1, 1'b0, 1'b0);
      #2;
      chk("to_idle_cyc", {31'b0, mem_cyc}, 32'h0);
      tick();
      for (int k = 1; k <= 12; k++) begin
         drive(1'b1, 1'b1, (k == 12));
         #2;
         chk($sformatf("to_w%0d_cerr", k), {31'b0, c_err}, {31'b0, (k == 4) || (k == 8)});
         chk($sformatf("to_w%0d_cack", k), {31'b0, c_ack}, {31'b0, k == 12});
         chk($sformatf("to_w%0d_dside", k), {30'b0, d_ack, d_err}, 32'h0);
         chk($sformatf("to_w%0d_grant", k), mem_addr, CA);
         chk($sformatf("to_w%0d_cyc", k), {31'b0, mem_cyc}, 32'h1);
         tick();
      end

      // CPU drops, DMA takes over, then reset in the middle of its transfer
      drive(1'b0, 1'b1, 1'b0);
      tick();
      #2;
      chk("hand_dma_grant", mem_addr, DA);
      chk("hand_dma_cyc", {31'b0, mem_cyc}, 32'h1);
      tick();
      mem_ack = 1'b1;
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_outputs", {24'b0, mem_cyc, mem_we, mem_strb, c_ack, d_ack}, 32'h0);
      chk("midrst_errs", {30'b0, c_err, d_err}, 32'h0);
      tick();
      tick();
      rst_n = 1'b1;
      #2;
      chk("postrst_idle", {29'b0, mem_cyc, d_ack, d_err}, 32'h0);
      tick();
      #2;
      chk("postrst_grant", {29'b0, mem_cyc, d_ack, d_err}, 32'h6);
      chk("postrst_addr", mem_addr, DA);
      tick();

      // randomized traffic against the reference model
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 1'b0);
      tick();
      rst_n  = 1'b1;
      m_own  = 0;
      m_last = 2;
      m_wait = 0;
      for (int n = 0; n < 3000; n++) begin
         if (c_cyc) c_cyc = ($urandom_range(0, 99) < 85);
         else       c_cyc = ($urandom_range(0, 99) < 30);
         if (d_cyc) d_cyc = ($urandom_range(0, 99) < 85);
         else       d_cyc = ($urandom_range(0, 99) < 30);
         mem_ack    = ($urandom_range(0, 99) < 35);
         c_we       = 1'($urandom);
         d_we       = 1'($urandom);
         c_strb     = 4'($urandom);
         d_strb     = 4'($urandom);
         c_addr     = $urandom;
         d_addr     = $urandom;
         c_data_i   = $urandom;
         d_data_i   = $urandom;
         mem_data_i = $urandom;
         #2;
         model_check();
         model_edge();
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, cycles a granted transfer may wait for mem_ack before error (range 1..255).
REQ-002 SHALL have ports clk input 1 (system clock) and rst_n input 1 (asynchronous active-low reset).
REQ-003 SHALL have c_cyc in 1, c_we in 1, c_strb in 4, c_addr in 32, c_data_i in 32 (CPU master request).
REQ-004 SHALL have c_ack out 1, c_err out 1, c_data_o out 32 (CPU master response).
REQ-005 SHALL have d_cyc in 1, d_we in 1, d_strb in 4, d_addr in 32, d_data_i in 32 (disk DMA master request, fed from DMA m_* outputs).
REQ-006 SHALL have d_ack out 1, d_err out 1, d_data_o out 32 (disk DMA master response, to DMA m_ack/m_data_i).
REQ-007 SHALL have mem_cyc out 1, mem_we out 1, mem_strb out 4, mem_addr out 32, mem_data_o out 32 (memory slave request).
REQ-008 SHALL have mem_ack in 1, mem_data_i in 32 (memory slave response).

Function
REQ-009 SHALL implement FSM states IDLE, GNT_C, GNT_D; state and last-grant flag registered.
REQ-010 IDLE: one requester -> grant it next cycle; both -> grant the master not granted last; none -> stay IDLE.
REQ-011 Request-to-grant latency SHALL be one cycle; mem_cyc first asserted the cycle after cyc seen in IDLE.
REQ-012 Grant SHALL be held while the granted master's cyc stays high, regardless of the other master's requests.
REQ-013 Granted master's cyc low at a clock edge: next state SHALL be grant-other if other cyc high, else IDLE.
REQ-014 mem_cyc/we/strb/addr/data_o SHALL be a combinational mux of the granted master; mem_cyc SHALL be 0 in IDLE.
REQ-015 mem_ack SHALL route combinationally to the granted master's ack only; the non-granted ack SHALL be 0.
REQ-016 c_data_o and d_data_o SHALL both equal mem_data_i (valid only with the respective ack).
REQ-017 Timeout counter (8 bit) SHALL clear on grant change, on mem_ack and in IDLE, and increment each cycle mem_cyc=1 and mem_ack=0.
REQ-018 Counter reaching TIMEOUT SHALL pulse granted master's err for one cycle, ack suppressed, counter cleared, grant kept.
REQ-019 mem_ack in the same cycle as counter reaching TIMEOUT SHALL win: ack delivered, no err.
REQ-020 mem_ack while in IDLE SHALL be ignored (no ack/err to either master).
REQ-021 Last-grant flag SHALL update on every entry into GNT_C or GNT_D.

Reset
REQ-022 rst_n low SHALL asynchronously force IDLE, last-grant=DMA (so CPU wins first tie), counter=0.
REQ-023 During/after reset all outputs SHALL be 0: mem_cyc, mem_we, mem_strb, c_ack, d_ack, c_err, d_err.
REQ-024 Reset mid-transfer SHALL abandon the transfer; no ack or err issued for it after rst_n deasserts.

Structure
REQ-025 Shared package SHALL hold state encoding (IDLE=2'b00, GNT_C=2'b01, GNT_D=2'b10), default TIMEOUT, grant-ID constants.
REQ-026 Timeout counter SHALL be sub-module arb_timer (inputs clr, inc; output expired).
REQ-027 Instantiated beside disk_top; d_* port to DMA master, c_* to CPU data port, mem_* to main memory.

Verification
REQ-028 Only d_cyc=1, d_we=1, d_addr=0x100, mem_ack after 2 cycles -> mem_cyc 1 cycle later, mem_addr=0x100, d_ack one cycle, c_ack=0.
REQ-029 c_cyc and d_cyc rise together from reset -> CPU granted first; after c_cyc drops, DMA granted next edge without IDLE.
REQ-030 Both held high over 4 transfers -> grants alternate C,D,C,D; no grant changes while granted cyc high.
REQ-031 TIMEOUT=4, c_cyc held, mem_ack never -> c_err pulses at 4th waiting cycle, c_ack=0, counter restarts, grant held.
REQ-032 mem_ack coincident with 4th waiting cycle (TIMEOUT=4) -> c_ack=1, c_err=0.
REQ-033 rst_n low mid DMA transfer -> all outputs 0 immediately; after release with d_cyc high, fresh grant after one cycle.
